// File: rtl/axil_arb_pkg.sv
// Shared types and AXI4-Lite response codes for the two-requester round-robin arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RESP,
    ST_DONE
  } state_e;

  localparam logic [1:0] OKAY         = 2'b00;
  localparam logic [1:0] EXOKAY       = 2'b01;
  localparam logic [1:0] SLVERR       = 2'b10;
  localparam logic [1:0] DECERR       = 2'b11;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/axil_rr_arbiter_if.sv
// AXI4-Lite channel bundle between the arbiter (master) and the downstream slave.
interface axil_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_rr_pick.sv
// Two-way round-robin picker: favours the requester that was not granted last.
module axil_rr_pick (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       any_o,
  output logic       grant_o
);

  logic last_q;

  // NOTE: every output is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    any_o   = |req_i;
    grant_o = req_i[~last_q] ? ~last_q : last_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Shares one AXI4-Lite master port between two req/ack requesters, one transaction at a time.
module axil_rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [1:0]            REQ,
  input  logic [1:0]            REQ_WE,
  input  logic [1:0][AW-1:0]    REQ_ADDR,
  input  logic [1:0][DW-1:0]    REQ_WDATA,
  input  logic [1:0][DW/8-1:0]  REQ_WSTRB,
  output logic [1:0]            ACK,
  output logic [DW-1:0]         RDATA,
  output logic [1:0]            RESP,
  output logic                  ERROR,
  axil_rr_arbiter_if.master     m_axi
);

  localparam bit              TMO_EN   = TIMEOUT > 0;
  localparam int              CW       = TMO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(TMO_EN ? TIMEOUT - 1 : 0);

  state_e          state_q;
  logic            grant_q, we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic [DW/8-1:0] wstrb_q;
  logic            awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic            aw_done_q, w_done_q;
  logic [1:0]      ack_q, resp_q;
  logic            error_q;
  logic [CW-1:0]   tmo_q;

  logic pick_any, pick_grant, pick_upd;
  logic aw_hs, w_hs, ar_hs, addr_done, resp_hs, tmo_hit;
  logic [1:0] resp_in;

  assign pick_upd = (state_q == ST_IDLE) && pick_any;

  axil_rr_pick u_pick (
    .clk      (ACLK),
    .rst      (ARESET),
    .req_i    (REQ),
    .update_i (pick_upd),
    .any_o    (pick_any),
    .grant_o  (pick_grant)
  );

  assign aw_hs     = awvalid_q && m_axi.awready;
  assign w_hs      = wvalid_q && m_axi.wready;
  assign ar_hs     = arvalid_q && m_axi.arready;
  // Write address and data may complete in either order; both must be seen before moving on.
  assign addr_done = we_q ? ((aw_done_q || aw_hs) && (w_done_q || w_hs)) : ar_hs;
  assign resp_hs   = we_q ? (bready_q && m_axi.bvalid) : (rready_q && m_axi.rvalid);
  assign resp_in   = we_q ? m_axi.bresp : m_axi.rresp;
  assign tmo_hit   = TMO_EN && (tmo_q == TMO_LAST);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      error_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q   <= pick_grant;
            we_q      <= REQ_WE[pick_grant];
            addr_q    <= REQ_ADDR[pick_grant];
            wdata_q   <= REQ_WDATA[pick_grant];
            wstrb_q   <= REQ_WSTRB[pick_grant];
            awvalid_q <= REQ_WE[pick_grant];
            wvalid_q  <= REQ_WE[pick_grant];
            arvalid_q <= ~REQ_WE[pick_grant];
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            tmo_q     <= '0;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (ar_hs) begin
            arvalid_q <= 1'b0;
          end
          if (addr_done) begin
            bready_q <= we_q;
            rready_q <= ~we_q;
            tmo_q    <= '0;
            state_q  <= ST_RESP;
          end else if (tmo_hit) begin
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rdata_q        <= '0;
            resp_q         <= RESP_TIMEOUT;
            error_q        <= 1'b1;
            ack_q[grant_q] <= 1'b1;
            tmo_q          <= '0;
            state_q        <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (resp_hs) begin
            bready_q       <= 1'b0;
            rready_q       <= 1'b0;
            rdata_q        <= we_q ? '0 : m_axi.rdata;
            resp_q         <= resp_in;
            error_q        <= error_q || resp_is_err(resp_in);
            ack_q[grant_q] <= 1'b1;
            tmo_q          <= '0;
            state_q        <= ST_DONE;
          end else if (tmo_hit) begin
            bready_q       <= 1'b0;
            rready_q       <= 1'b0;
            rdata_q        <= '0;
            resp_q         <= RESP_TIMEOUT;
            error_q        <= 1'b1;
            ack_q[grant_q] <= 1'b1;
            tmo_q          <= '0;
            state_q        <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        ST_DONE: begin
          tmo_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ACK   = ack_q;
  assign RDATA = rdata_q;
  assign RESP  = resp_q;
  assign ERROR = error_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule
